// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with fast-path special cases.
// Define DIV_RADIX4_EN to retire two quotient bits per CALC cycle (16 iterations instead of 32).
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_valid,
    input  logic [1:0]      DIVop,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic [XLEN-1:0] div_result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_REM = 2'b10;

`ifdef DIV_RADIX4_EN
    localparam logic [4:0] LAST_CNT = 5'd15;
`else
    localparam logic [4:0] LAST_CNT = 5'd31;
`endif

    logic [1:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            sign_q_q, sign_q_d;
    logic            sign_r_q, sign_r_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] div_result_q, div_result_d;

    logic [2*XLEN-1:0] step_nxt;
`ifdef DIV_RADIX4_EN
    logic [2*XLEN-1:0] step_mid;
`endif
    logic [XLEN-1:0] q_fin, r_fin;
    logic            signed_op;

    // One restoring step: the shifted partial remainder is XLEN+1 bits wide for the compare.
    function automatic logic [2*XLEN-1:0] restore_step(input logic [XLEN-1:0] rem,
                                                       input logic [XLEN-1:0] quo,
                                                       input logic [XLEN-1:0] dvsr);
        logic [XLEN:0]   part;
        logic [XLEN-1:0] q;
        part = {rem, quo[XLEN-1]};
        q    = {quo[XLEN-2:0], 1'b0};
        if (part >= {1'b0, dvsr}) begin
            part = part - {1'b0, dvsr};
            q[0] = 1'b1;
        end
        return {part[XLEN-1:0], q};
    endfunction

    // 32'h80000000 maps to 2^31, which still fits the unsigned register.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvsr_d       = dvsr_q;
        sign_q_d     = sign_q_q;
        sign_r_d     = sign_r_q;
        cnt_d        = cnt_q;
        div_result_d = div_result_q;
        signed_op    = ~DIVop[0];

`ifdef DIV_RADIX4_EN
        step_mid = restore_step(rem_q, quo_q, dvsr_q);
        step_nxt = restore_step(step_mid[2*XLEN-1:XLEN], step_mid[XLEN-1:0], dvsr_q);
`else
        step_nxt = restore_step(rem_q, quo_q, dvsr_q);
`endif
        q_fin = (op_q == OP_DIV && sign_q_q) ? (~step_nxt[XLEN-1:0] + 1'b1)
                                             : step_nxt[XLEN-1:0];
        r_fin = (op_q == OP_REM && sign_r_q) ? (~step_nxt[2*XLEN-1:XLEN] + 1'b1)
                                             : step_nxt[2*XLEN-1:XLEN];

        case (state_q)
            S_IDLE: begin
                if (div_valid) begin
                    op_d     = DIVop;
                    rem_d    = '0;
                    quo_d    = magnitude(dividend, signed_op);
                    dvsr_d   = magnitude(divisor, signed_op);
                    sign_q_d = dividend[XLEN-1] ^ divisor[XLEN-1];
                    sign_r_d = dividend[XLEN-1];
                    cnt_d    = '0;
                    // Special cases load the final answer directly and skip sign correction.
                    if (divisor == '0) begin
                        state_d      = S_DONE;
                        div_result_d = DIVop[1] ? dividend : '1;
                    end else if (signed_op && dividend == {1'b1, {(XLEN-1){1'b0}}} &&
                                 divisor == '1) begin
                        state_d      = S_DONE;
                        div_result_d = DIVop[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_nxt[2*XLEN-1:XLEN];
                quo_d = step_nxt[XLEN-1:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d      = S_DONE;
                    div_result_d = op_q[1] ? r_fin : q_fin;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            sign_q_q     <= 1'b0;
            sign_r_q     <= 1'b0;
            cnt_q        <= '0;
            div_result_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvsr_q       <= dvsr_d;
            sign_q_q     <= sign_q_d;
            sign_r_q     <= sign_r_d;
            cnt_q        <= cnt_d;
            div_result_q <= div_result_d;
        end
    end

    assign div_ready  = (state_q == S_DONE);
    assign busy       = (state_q == S_CALC) || (state_q == S_DONE);
    assign div_result = div_result_q;

endmodule
